// File: rtl/hbmc_bus_sync_filter.sv
// hbmc_bus_sync_filter
// Multi-channel CDC synchronizer with a per-channel debounce filter.
// Each channel: C_SYNC_STAGES-deep flop chain, then a counter that needs
// C_FILTER_LEN consecutive differing samples before q flips. rise/fall
// pulse on the edge that updates q; changed is the registered OR of all pulses.
module hbmc_bus_sync_filter #(
    parameter int unsigned           C_WIDTH       = 4,
    parameter int unsigned           C_SYNC_STAGES = 3,
    parameter int unsigned           C_FILTER_LEN  = 4,
    parameter logic [C_WIDTH-1:0]    C_RESET_STATE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] d,
    output logic [C_WIDTH-1:0] q,
    output logic [C_WIDTH-1:0] rise,
    output logic [C_WIDTH-1:0] fall,
    output logic               changed
);

    localparam int unsigned CNT_W_RAW = $clog2(C_FILTER_LEN + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_LEN - 1);

    if (C_SYNC_STAGES < 2 || C_FILTER_LEN < 1 || C_WIDTH < 1 || C_WIDTH > 32) begin : g_param_err
        $error("hbmc_bus_sync_filter: illegal parameters (C_WIDTH=%0d C_SYNC_STAGES=%0d C_FILTER_LEN=%0d)",
               C_WIDTH, C_SYNC_STAGES, C_FILTER_LEN);
    end

    // Next-cycle pulse per channel, gathered for the aggregate flag
    logic [C_WIDTH-1:0] pulse_d;
    logic               changed_d;
    logic               changed_q;

    for (genvar i = 0; i < C_WIDTH; i++) begin : g_ch
        (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
        logic [C_SYNC_STAGES-1:0] sync_q;
        logic [C_SYNC_STAGES-1:0] sync_d;
        logic                     sync_out;
        logic [CNT_W-1:0]         cnt_q;
        logic [CNT_W-1:0]         cnt_d;
        logic                     q_q;
        logic                     q_d;
        logic                     rise_q;
        logic                     rise_d;
        logic                     fall_q;
        logic                     fall_d;

        assign sync_out = sync_q[C_SYNC_STAGES-1];

        // Shift chain and debounce counter next-state
        always_comb begin
            sync_d = {sync_q[C_SYNC_STAGES-2:0], d[i]};
            q_d    = q_q;
            cnt_d  = cnt_q;
            if (sync_out == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                q_d   = sync_out;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            rise_d = q_d & ~q_q;
            fall_d = ~q_d & q_q;
        end

        // Channel state; reset reloads the chain so no pulse can follow release
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= {C_SYNC_STAGES{C_RESET_STATE[i]}};
                cnt_q  <= '0;
                q_q    <= C_RESET_STATE[i];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                q_q    <= q_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign pulse_d[i] = rise_d | fall_d;
        assign q[i]       = q_q;
        assign rise[i]    = rise_q;
        assign fall[i]    = fall_q;
    end

    // Aggregate change flag, registered alongside the per-channel pulses
    always_comb begin
        changed_d = |pulse_d;
    end

    // Changed flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_hbmc_bus_sync_filter.sv
// Directed bench for hbmc_bus_sync_filter: default build with reset state
// 4'b0101, plus a minimal build (2 stages, filter length 1, reset state 0).
module tb_hbmc_bus_sync_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic [3:0] q, rise, fall;
    logic       changed;
    logic       rst2;
    logic [3:0] d2;
    logic [3:0] q2, rise2, fall2;
    logic       changed2;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    hbmc_bus_sync_filter #(
        .C_WIDTH       (4),
        .C_SYNC_STAGES (3),
        .C_FILTER_LEN  (4),
        .C_RESET_STATE (4'b0101)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    hbmc_bus_sync_filter #(
        .C_WIDTH       (4),
        .C_SYNC_STAGES (2),
        .C_FILTER_LEN  (1),
        .C_RESET_STATE (4'b0000)
    ) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .d       (d2),
        .q       (q2),
        .rise    (rise2),
        .fall    (fall2),
        .changed (changed2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then check the selected instance's outputs
    task automatic step_chk(input string tag, input bit sel, input logic [3:0] eq,
                            input logic [3:0] er, input logic [3:0] ef, input logic ec);
        @(posedge clk);
        #1;
        if (!sel) begin
            chk({tag, ".q"},       {28'd0, q},       {28'd0, eq});
            chk({tag, ".rise"},    {28'd0, rise},    {28'd0, er});
            chk({tag, ".fall"},    {28'd0, fall},    {28'd0, ef});
            chk({tag, ".changed"}, {31'd0, changed}, {31'd0, ec});
        end else begin
            chk({tag, ".q2"},       {28'd0, q2},       {28'd0, eq});
            chk({tag, ".rise2"},    {28'd0, rise2},    {28'd0, er});
            chk({tag, ".fall2"},    {28'd0, fall2},    {28'd0, ef});
            chk({tag, ".changed2"}, {31'd0, changed2}, {31'd0, ec});
        end
    endtask

    task automatic quiet(input string tag, input bit sel, input int unsigned n, input logic [3:0] eq);
        for (int unsigned k = 0; k < n; k++) begin
            step_chk(tag, sel, eq, 4'b0000, 4'b0000, 1'b0);
        end
    endtask

    initial begin
        rst  = 1'b1;
        d    = 4'b0101;
        rst2 = 1'b1;
        d2   = 4'b0000;

        // 1: reset holds q at reset state, no pulses during or after release
        quiet("rst", 0, 5, 4'b0101);
        rst = 1'b0;
        quiet("post_rst", 0, 4, 4'b0101);

        // 2: d[1] rises; q[1] follows on the 7th edge
        d = 4'b0111;
        quiet("lat7", 0, 6, 4'b0101);
        step_chk("lat7_rise", 0, 4'b0111, 4'b0010, 4'b0000, 1'b1);
        quiet("lat7_after", 0, 2, 4'b0111);

        // 3a: 3-cycle low glitch on d[0] is rejected
        d = 4'b0110;
        quiet("g3_lo", 0, 3, 4'b0111);
        d = 4'b0111;
        quiet("g3_hi", 0, 9, 4'b0111);

        // 3b: 4-cycle low passes: fall on 7th edge, rise 4 edges later
        d = 4'b0110;
        quiet("g4_lo", 0, 4, 4'b0111);
        d = 4'b0111;
        quiet("g4_hi", 0, 2, 4'b0111);
        step_chk("g4_fall", 0, 4'b0110, 4'b0000, 4'b0001, 1'b1);
        quiet("g4_mid", 0, 3, 4'b0110);
        step_chk("g4_rise", 0, 4'b0111, 4'b0001, 4'b0000, 1'b1);
        quiet("g4_end", 0, 1, 4'b0111);

        // 4: 3 high / 1 low / 3 high / 1 low on d[3], then held high
        d = 4'b1111; quiet("alt_a", 0, 3, 4'b0111);
        d = 4'b0111; quiet("alt_b", 0, 1, 4'b0111);
        d = 4'b1111; quiet("alt_c", 0, 3, 4'b0111);
        d = 4'b0111; quiet("alt_d", 0, 1, 4'b0111);
        d = 4'b1111; quiet("alt_hold", 0, 6, 4'b0111);
        step_chk("alt_rise", 0, 4'b1111, 4'b1000, 4'b0000, 1'b1);
        quiet("alt_end", 0, 1, 4'b1111);

        // 5: simultaneous multi-channel transitions
        d = 4'b0101;
        quiet("multi_a", 0, 6, 4'b1111);
        step_chk("multi_a_fall", 0, 4'b0101, 4'b0000, 4'b1010, 1'b1);
        quiet("multi_a_end", 0, 1, 4'b0101);
        d = 4'b1010;
        quiet("multi_b", 0, 6, 4'b0101);
        step_chk("multi_b_edge", 0, 4'b1010, 4'b1010, 4'b0101, 1'b1);
        quiet("multi_b_end", 0, 1, 4'b1010);
        d = 4'b0101;
        quiet("multi_c", 0, 6, 4'b1010);
        step_chk("multi_c_edge", 0, 4'b0101, 4'b0101, 4'b1010, 1'b1);
        quiet("multi_c_end", 0, 1, 4'b0101);

        // 6a: reset while d[2] is mid-filter (cnt=2) discards the count
        d = 4'b0001;
        quiet("midrst_pre", 0, 5, 4'b0101);
        rst = 1'b1;
        step_chk("midrst_rst", 0, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        quiet("midrst_post", 0, 6, 4'b0101);
        step_chk("midrst_fall", 0, 4'b0001, 4'b0000, 4'b0100, 1'b1);
        quiet("midrst_end", 0, 1, 4'b0001);

        // 6b: minimal build, 3-edge latency and back-to-back pulses
        quiet("m_rst", 1, 2, 4'b0000);
        rst2 = 1'b0;
        d2 = 4'b0001;
        quiet("m_lat", 1, 2, 4'b0000);
        step_chk("m_rise", 1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        quiet("m_idle", 1, 1, 4'b0001);
        d2 = 4'b0000; step_chk("m_t1", 1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        d2 = 4'b0001; step_chk("m_t2", 1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        d2 = 4'b0000; step_chk("m_t3", 1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        d2 = 4'b0001; step_chk("m_t4", 1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        d2 = 4'b0000; step_chk("m_t5", 1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        d2 = 4'b0001; step_chk("m_t6", 1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        step_chk("m_t7", 1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        step_chk("m_t8", 1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        quiet("m_end", 1, 2, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hbmc_bus_sync_filter.md
Name: hbmc_bus_sync_filter

Overview:
- Multi-channel successor to the single-bit synchronizer.
- Brings C_WIDTH independent asynchronous inputs into the clk domain through a C_SYNC_STAGES flip-flop chain per channel.
- Each channel then passes through a glitch/debounce filter that requires C_FILTER_LEN consecutive identical samples before the output changes.
- Produces one-cycle rise/fall pulses per channel plus an aggregate change flag. Intended for HyperBus status lines (RWDS idle, INT#, RSTO#) and slow control inputs crossing into the controller clock.

Parameters:
C_WIDTH, 4, number of independent channels (1..32)
C_SYNC_STAGES, 3, synchronizer flip-flops per channel (>=2)
C_FILTER_LEN, 4, consecutive differing synchronized samples required to change the output (>=1)
C_RESET_STATE, {C_WIDTH{1'b0}}, C_WIDTH-bit reset value of the sync chain and of q

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
d  input  C_WIDTH  asynchronous inputs, one per channel
q  output  C_WIDTH  synchronized, filtered level
rise  output  C_WIDTH  one-cycle pulse when q[i] goes 0->1
fall  output  C_WIDTH  one-cycle pulse when q[i] goes 1->0
changed  output  1  OR-reduction of (rise | fall), registered

Behaviour:
- Interface fixed: one clock clk; reset rst is synchronous and active-high.
- Sync chain per channel:
  - s[i][0] <= d[i], s[i][k] <= s[i][k-1].
  - sync_out[i] = s[i][C_SYNC_STAGES-1].
  - Chain registers carry ASYNC_REG and no-SRL-extraction attributes.
- Filter counter per channel: width clog2(C_FILTER_LEN+1), minimum 1 bit.
  - If sync_out[i] == q[i]: cnt[i] <= 0.
  - Else if cnt[i] == C_FILTER_LEN-1: q[i] <= sync_out[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - C_FILTER_LEN=1 means q follows sync_out one edge later, with no filtering.
- Latency: d[i] stable before posedge N is reflected on q[i] after posedge N+C_SYNC_STAGES+C_FILTER_LEN-1. This is C_SYNC_STAGES+C_FILTER_LEN edges, counting edge N.
- Glitch rejection:
  - A sync_out deviation lasting fewer than C_FILTER_LEN consecutive cycles never changes q.
  - A return to q's value clears cnt; counts do not accumulate across separate glitches.
- Edge pulses:
  - rise[i], fall[i] and changed are registered on the same edge that updates q[i].
  - Each is high for exactly one cycle, coincident with the first cycle of the new q value.
  - rise[i] and fall[i] are never both high.
  - A channel cannot pulse in consecutive cycles unless C_FILTER_LEN=1.
- Channels are fully independent. Simultaneous transitions on several channels give concurrent pulses on each, with a single-cycle changed.
- Reset, synchronous, priority over all else:
  - s <= C_RESET_STATE replicated per stage.
  - q <= C_RESET_STATE.
  - cnt <= 0.
  - rise, fall, changed <= 0.
- Reset asserted mid-filter discards partial counts.
- No pulse is generated during reset or on the first cycle after release, even if d differs from C_RESET_STATE. The difference then propagates with normal latency and produces a normal pulse.
- Parameter guard: C_SYNC_STAGES<2, C_FILTER_LEN<1 or C_WIDTH<1 causes an elaboration error via generate-time check.

Test Plan:
1. Defaults, C_RESET_STATE=4'b0101, rst high 5 cycles with d=4'b0101 -> q=4'b0101, rise=fall=0, changed=0 throughout and after release.
2. d[1] 0->1 held -> q[1]=1 exactly 7 edges after first sampling edge; rise[1]=1 for one cycle on that edge, changed=1 same cycle; other bits of q unchanged.
3. d[0] pulsed low for 3 cycles (< C_FILTER_LEN=4), then high again -> q[0] stays 1, fall[0] never asserts. Repeat with a 4-cycle low -> q[0]=0 and fall[0] pulses once.
4. Alternating glitches on d[3]: 3 cycles high, 1 low, 3 high -> no change on q[3], since the count resets. Then hold high -> rise[3] after 7 edges.
5. d=4'b1010 applied in one cycle from 4'b0101 -> rise=4'b1010 and fall=4'b0101 in the same single cycle, changed=1 for one cycle.
6. Assert rst for one cycle while d[2] is mid-filter (cnt=2) -> q[2]=C_RESET_STATE[2], no pulse. The change reappears with full 7-edge latency. Rerun with C_FILTER_LEN=1, C_SYNC_STAGES=2 -> 3-edge latency, pulses on back-to-back toggles.
